// File: rtl/bcd_disp_pkg.sv
// Shared types and segment constants for the BCD seven-segment display.
// Segments are active-low, packed {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Digit-to-segment table, indexed by the 4-bit digit; codes 10..15 show a dash.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/bcd_digit_seg.sv
// One BCD digit to active-low seven-segment code, with a blank override.
module bcd_digit_seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  // Table lookup, forced dark when blanked.
  always_comb begin
    o_seg = SEG_TABLE[i_digit];
    if (i_blank) o_seg = SEG_BLANK;
  end

endmodule

// File: rtl/bcd_seg_display.sv
// Three-digit BCD display with a valid/ready capture handshake, a minimum
// display hold time, leading-zero blanking and registered segment outputs.
// Optional blink in SHOW state: define BCD_DISP_BLINK_EN.
module bcd_seg_display
  import bcd_disp_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned BLINK_HALF  = 25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd_in,
  input  logic        bcd_valid,
  output logic        bcd_ready,
  input  logic        clear,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX0
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255 || BLINK_HALF < 1) begin : g_bad_param
    $error("bcd_seg_display: HOLD_CYCLES must be 1..255 and BLINK_HALF >= 1");
  end

  localparam logic [7:0] LP_HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_ready;
  logic        w_xfer;
  logic [11:0] r_capt;
  logic [7:0]  r_hold_cnt;
  logic        w_blank_all;
  logic [6:0]  w_seg2, w_seg1, w_seg0;
  logic [6:0]  r_hex2, r_hex1, r_hex0;

  // clear wins over a pending transfer; HOLD never accepts.
  assign w_xfer    = bcd_valid & ~clear & (r_state != ST_HOLD);
  assign bcd_ready = w_ready;
  assign HEX2      = r_hex2;
  assign HEX1      = r_hex1;
  assign HEX0      = r_hex0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and ready decode.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b1;
    case (r_state)
      ST_IDLE: if (w_xfer) w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        w_ready = 1'b0;
        if (r_hold_cnt == '0) w_state_nxt = ST_SHOW;
      end
      ST_SHOW: if (w_xfer) w_state_nxt = ST_HOLD;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (clear) w_state_nxt = ST_IDLE;
  end

  // Captured value and hold countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_capt     <= '0;
      r_hold_cnt <= '0;
    end else if (clear) begin
      r_capt     <= '0;
      r_hold_cnt <= '0;
    end else if (w_xfer) begin
      r_capt     <= bcd_in;
      r_hold_cnt <= LP_HOLD_LOAD;
    end else if (r_state == ST_HOLD && r_hold_cnt != '0) begin
      r_hold_cnt <= r_hold_cnt - 8'd1;
    end
  end

`ifdef BCD_DISP_BLINK_EN
  localparam logic [31:0] LP_BLINK_LAST = 32'(BLINK_HALF - 1);

  logic [31:0] r_blink_cnt;
  logic        r_blink_phase;

  // Blink timer runs only in SHOW; restarts dark-free on every transfer or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (clear || w_xfer) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_state == ST_SHOW) begin
      if (r_blink_cnt == LP_BLINK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 32'd1;
      end
    end
  end

  assign w_blank_all = (r_state == ST_IDLE) | ((r_state == ST_SHOW) & r_blink_phase);
`else
  assign w_blank_all = (r_state == ST_IDLE);
`endif

  bcd_digit_seg u_seg2 (
    .i_digit (r_capt[11:8]),
    .i_blank (w_blank_all | (r_capt[11:8] == 4'd0)),
    .o_seg   (w_seg2)
  );

  bcd_digit_seg u_seg1 (
    .i_digit (r_capt[7:4]),
    .i_blank (w_blank_all | (r_capt[11:4] == 8'd0)),
    .o_seg   (w_seg1)
  );

  bcd_digit_seg u_seg0 (
    .i_digit (r_capt[3:0]),
    .i_blank (w_blank_all),
    .o_seg   (w_seg0)
  );

  // Segment output registers; they trail the capture register by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hex2 <= SEG_BLANK;
      r_hex1 <= SEG_BLANK;
      r_hex0 <= SEG_BLANK;
    end else begin
      r_hex2 <= w_seg2;
      r_hex1 <= w_seg1;
      r_hex0 <= w_seg0;
    end
  end

endmodule

// File: tb/tb_bcd_seg_display.sv
// Randomized self-checking bench for bcd_seg_display against a behavioural
// model (busy-cycle count, displayed value, cycles spent showing).
module tb_bcd_seg_display;

  localparam int unsigned TB_HOLD  = 4;
  localparam int unsigned TB_BLINK = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] bcd_in = '0;
  logic        bcd_valid = 1'b0;
  logic        bcd_ready;
  logic        clear = 1'b0;
  logic [6:0]  HEX2, HEX1, HEX0;

  always #5 clk = ~clk;

  bcd_seg_display #(
    .HOLD_CYCLES (TB_HOLD),
    .BLINK_HALF  (TB_BLINK)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_in    (bcd_in),
    .bcd_valid (bcd_valid),
    .bcd_ready (bcd_ready),
    .clear     (clear),
    .HEX2      (HEX2),
    .HEX1      (HEX1),
    .HEX0      (HEX0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_ref [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model state
  bit          m_active;
  logic [11:0] m_val;
  int          m_busy;
  int          m_show_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] digit_seg(input int d);
    if (d <= 9) return seg_ref[d];
    return 7'h3F;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_val    = '0;
    m_busy   = 0;
    m_show_n = 0;
  endtask

  task automatic expected_hex(output logic [6:0] e2, output logic [6:0] e1, output logic [6:0] e0);
    int h, t, o;
    bit dark;
    h = int'(m_val[11:8]);
    t = int'(m_val[7:4]);
    o = int'(m_val[3:0]);
    dark = !m_active;
`ifdef BCD_DISP_BLINK_EN
    if (m_active && m_busy == 0 && ((m_show_n / int'(TB_BLINK)) % 2) == 1) dark = 1'b1;
`endif
    if (dark) begin
      e2 = 7'h7F; e1 = 7'h7F; e0 = 7'h7F;
    end else begin
      e2 = (h == 0) ? 7'h7F : digit_seg(h);
      e1 = (h == 0 && t == 0) ? 7'h7F : digit_seg(t);
      e0 = digit_seg(o);
    end
  endtask

  task automatic step(input logic v, input logic [11:0] d, input logic c);
    logic [6:0] e2, e1, e0;
    bcd_valid = v;
    bcd_in    = d;
    clear     = c;
    @(posedge clk);
    expected_hex(e2, e1, e0);
    if (c) begin
      model_reset();
    end else if (v && m_busy == 0) begin
      m_val    = d;
      m_active = 1'b1;
      m_busy   = int'(TB_HOLD);
      m_show_n = 0;
    end else if (m_busy > 0) begin
      m_busy--;
    end else if (m_active) begin
      m_show_n++;
    end
    #1;
    chk("HEX2", 32'(HEX2), 32'(e2));
    chk("HEX1", 32'(HEX1), 32'(e1));
    chk("HEX0", 32'(HEX0), 32'(e0));
    chk("ready", 32'(bcd_ready), 32'(m_busy == 0));
  endtask

  // Called 1 time unit after an edge: asserts reset between edges, checks the
  // outputs react without a clock, and releases before the next edge.
  task automatic async_reset();
    bcd_valid = 1'b0;
    clear     = 1'b0;
    rst_n     = 1'b0;
    #2;
    model_reset();
    chk("rst_HEX2", 32'(HEX2), 32'h7F);
    chk("rst_HEX1", 32'(HEX1), 32'h7F);
    chk("rst_HEX0", 32'(HEX0), 32'h7F);
    chk("rst_ready", 32'(bcd_ready), 32'h1);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [11:0] d;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    chk("init_HEX2", 32'(HEX2), 32'h7F);
    chk("init_HEX1", 32'(HEX1), 32'h7F);
    chk("init_HEX0", 32'(HEX0), 32'h7F);
    chk("init_ready", 32'(bcd_ready), 32'h1);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // 255 right after reset release, then hold/show timing
    step(1'b1, 12'h255, 1'b0);
    repeat (6) step(1'b0, 12'h000, 1'b0);

    // Leading-zero blanking
    step(1'b1, 12'h007, 1'b0);
    repeat (5) step(1'b0, 12'h000, 1'b0);
    step(1'b1, 12'h000, 1'b0);
    repeat (5) step(1'b0, 12'h000, 1'b0);

    // valid held through HOLD is ignored until ready returns
    step(1'b1, 12'h123, 1'b0);
    repeat (5) step(1'b1, 12'h456, 1'b0);
    repeat (5) step(1'b0, 12'h000, 1'b0);

    // Dash digit, then clear beating valid, then clear in IDLE with valid
    step(1'b1, 12'h1A3, 1'b0);
    repeat (5) step(1'b0, 12'h000, 1'b0);
    step(1'b1, 12'h789, 1'b1);
    step(1'b1, 12'h789, 1'b1);
    repeat (2) step(1'b0, 12'h000, 1'b0);

    // Async reset mid-HOLD, then transfer on first edge after release
    step(1'b1, 12'h321, 1'b0);
    step(1'b0, 12'h000, 1'b0);
    async_reset();
    step(1'b1, 12'h042, 1'b0);
    repeat (5) step(1'b0, 12'h000, 1'b0);

    // Single digit held long enough to exercise blink when enabled
    step(1'b1, 12'h009, 1'b0);
    repeat (16) step(1'b0, 12'h000, 1'b0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      d = 12'($urandom);
      case ($urandom_range(0, 3))
        0: d[11:8] = 4'd0;
        1: d[11:4] = 8'd0;
        default: ;
      endcase
      if ($urandom_range(0, 59) == 0) begin
        async_reset();
      end
      step(1'($urandom_range(0, 2) != 0), d, 1'($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 9) == 0) repeat ($urandom_range(1, 12)) step(1'b0, 12'h000, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
